// File: rtl/cic_decim.sv
// -----------------------------------------------------------------------------
// cic_decim
//   Third-order CIC (sinc^3) decimator for the 1-bit delta-sigma bitstream.
//   Each accepted input bit maps to +1/-1. The bits pass through three
//   integrators at the fast rate. Every DECIM accepted bits, the last
//   integrator is sampled and run through three comb (difference) stages.
//   This produces one WIDTH-bit signed sample with gain DECIM^3.
//
// Ports
//   clock      in   1      fast clock
//   reset      in   1      synchronous, active-high; clears all state/outputs
//   in_en      in   1      qualifies bit_in; all state holds when low
//   bit_in     in   1      bitstream, 1 = +1, 0 = -1
//   dec_o      out  WIDTH  decimated sample, two's complement (registered)
//   dec_valid  out  1      one-cycle strobe, dec_o updated this cycle
// -----------------------------------------------------------------------------
module cic_decim #(
  parameter int DECIM = 50,
  parameter int WIDTH = 20
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_en,
  input  logic                    bit_in,
  output logic signed [WIDTH-1:0] dec_o,
  output logic                    dec_valid
);

  localparam int CNT_W = (DECIM > 2) ? $clog2(DECIM) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

  localparam logic [WIDTH-1:0] W_ZERO    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] W_PLUS1   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] W_MINUS1  = {WIDTH{1'b1}};

  // Integrator cascade. All arithmetic is modulo 2^WIDTH. The wrap cancels
  // in the combs, so it is intentional and never flagged.
  logic [WIDTH-1:0] i1_r, i2_r, i3_r;
  // Comb delay elements, loaded only on a decimation tick
  logic [WIDTH-1:0] d1_r, d2_r, d3_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] dec_r;
  logic             dec_valid_r;

  logic [WIDTH-1:0] x_s;
  logic             tick_s;
  logic [WIDTH-1:0] c1_s, c2_s, c3_s;

  // Input mapping, tick detection and comb differences at the decimated rate
  always_comb begin
    x_s    = W_ZERO;
    tick_s = 1'b0;
    if (bit_in) begin
      x_s = W_PLUS1;
    end else begin
      x_s = W_MINUS1;
    end
    if (in_en && (cnt_r == CNT_LAST)) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end
    // The combs see the pre-edge value of the last integrator
    c1_s = i3_r - d1_r;
    c2_s = c1_s - d2_r;
    c3_s = c2_s - d3_r;
  end

  // Integrators: registered cascade. Each stage adds the previous stage's
  // pre-edge value, so i3 trails the input by two accepted bits.
  always_ff @(posedge clock) begin
    if (reset) begin
      i1_r <= W_ZERO;
      i2_r <= W_ZERO;
      i3_r <= W_ZERO;
    end else if (in_en) begin
      i1_r <= i1_r + x_s;
      i2_r <= i2_r + i1_r;
      i3_r <= i3_r + i2_r;
    end
  end

  // Decimation counter: counts accepted bits 0..DECIM-1 and wraps
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_r <= CNT_ZERO;
    end else if (in_en) begin
      if (cnt_r == CNT_LAST) begin
        cnt_r <= CNT_ZERO;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  // Comb delays: capture the stage inputs on each tick
  always_ff @(posedge clock) begin
    if (reset) begin
      d1_r <= W_ZERO;
      d2_r <= W_ZERO;
      d3_r <= W_ZERO;
    end else if (tick_s) begin
      d1_r <= i3_r;
      d2_r <= c1_s;
      d3_r <= c2_s;
    end
  end

  // Output register: new sample plus strobe on a tick, otherwise hold value
  always_ff @(posedge clock) begin
    if (reset) begin
      dec_r       <= W_ZERO;
      dec_valid_r <= 1'b0;
    end else begin
      dec_valid_r <= tick_s;
      if (tick_s) begin
        dec_r <= c3_s;
      end
    end
  end

  assign dec_o     = dec_r;
  assign dec_valid = dec_valid_r;

endmodule

// File: tb/tb_cic_decim.sv
// -----------------------------------------------------------------------------
// tb_cic_decim
//   Scoreboard bench for cic_decim. The stimulus side runs a golden sinc^3
//   model. For each accepted bit, the model integrates with the two-bit lag.
//   On each tick, it forms the third difference of the sampled integrator
//   values. Each expected sample is pushed into a queue, optionally with a
//   hand-computed steady-state value. A separate monitor pops the queue on
//   every dec_valid and checks the hold behaviour in all other cycles.
// -----------------------------------------------------------------------------
module tb_cic_decim;

  localparam int DECIM = 50;
  localparam int WIDTH = 20;

  logic                    clock;
  logic                    reset;
  logic                    in_en;
  logic                    bit_in;
  logic signed [WIDTH-1:0] dec_o;
  logic                    dec_valid;

  cic_decim #(.DECIM(DECIM), .WIDTH(WIDTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_en     (in_en),
    .bit_in    (bit_in),
    .dec_o     (dec_o),
    .dec_valid (dec_valid)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic signed [WIDTH-1:0] val;
    int                      cyc;
    bit                      has_hand;
    int                      hand;
  } exp_t;

  exp_t sbq[$];
  logic signed [WIDTH-1:0] cap[$];
  logic signed [WIDTH-1:0] cap_a[$];
  logic signed [WIDTH-1:0] cap_b[$];
  logic pat[0:399];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit mon_on = 1'b0;
  bit hold_zero = 1'b0;
  bit prev_valid = 1'b0;
  logic signed [WIDTH-1:0] last_dec = '0;

  // hand-checked steady-state value, applied from strobe hand_from onward (0 = off)
  int hand_from = 0;
  int hand_val = 0;

  // golden model state
  logic signed [WIDTH-1:0] m_i1, m_i2, m_i3, sp1, sp2, sp3;
  int m_cnt, m_strobe;

  task automatic chk(input string nm, input longint got, input longint want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  task automatic model(input logic r, input logic en, input logic b);
    logic signed [WIDTH-1:0] s, e, x;
    exp_t ent;
    if (r) begin
      m_i1 = '0; m_i2 = '0; m_i3 = '0;
      sp1 = '0; sp2 = '0; sp3 = '0;
      m_cnt = 0; m_strobe = 0;
    end else if (en) begin
      s = m_i3;
      if (m_cnt == DECIM - 1) begin
        // third difference of successive integrator samples, zero history before reset
        e = WIDTH'(s - 3 * sp1 + 3 * sp2 - sp3);
        m_strobe++;
        ent.val = e;
        ent.cyc = cyc;
        ent.has_hand = (hand_from > 0) && (m_strobe >= hand_from);
        ent.hand = hand_val;
        sbq.push_back(ent);
        sp3 = sp2; sp2 = sp1; sp1 = s;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
      x = b ? 20'sd1 : -20'sd1;
      m_i3 = m_i3 + m_i2;
      m_i2 = m_i2 + m_i1;
      m_i1 = m_i1 + x;
    end
  endtask

  task automatic step(input logic r, input logic en, input logic b);
    reset = r; in_en = en; bit_in = b;
    @(posedge clock);
    cyc++;
    model(r, en, b);
    hold_zero = r;
    #1;
  endtask

  function automatic logic bit_of(input int mode, input int k);
    logic [4:0] p5;
    p5 = 5'b01111;
    case (mode)
      0: return 1'b1;
      1: return 1'b0;
      2: return (k % 2 == 0) ? 1'b1 : 1'b0;
      3: return p5[k % 5];
      4: return pat[k % 400];
      default: return ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0;
    endcase
  endfunction

  // run n_acc accepted bits; rand_en chooses gap-free or random in_en
  task automatic run(input int mode, input int n_acc, input bit rand_en);
    int k, guard;
    logic en;
    k = 0; guard = 0;
    while (k < n_acc && guard < 20 * n_acc + 100) begin
      en = rand_en ? (($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0) : 1'b1;
      step(1'b0, en, bit_of(mode, k));
      if (en) k++;
      guard++;
    end
    if (k < n_acc) chk("run_budget", k, n_acc);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 1'b1);
    chk("reset_dec_o", dec_o, 0);
    chk("reset_dec_valid", dec_valid, 0);
    cap.delete();
  endtask

  task automatic drain();
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("queue_empty", sbq.size(), 0);
    sbq.delete();
  endtask

  task automatic cmp_caps(input string nm);
    chk({nm, "_len"}, cap_b.size(), cap_a.size());
    for (int i = 0; i < cap_a.size() && i < cap_b.size(); i++)
      chk(nm, cap_b[i], cap_a[i]);
  endtask

  // monitor: pop and compare on every strobe, check hold otherwise
  always @(negedge clock) begin
    exp_t e;
    if (mon_on) begin
      if (dec_valid) begin
        chk("no_back_to_back", prev_valid, 0);
        if (sbq.size() == 0) begin
          chk("unexpected_strobe", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("strobe_cycle", cyc, e.cyc);
          chk("dec_golden", dec_o, e.val);
          if (e.has_hand) chk("dec_hand", dec_o, e.hand);
        end
        cap.push_back(dec_o);
      end else begin
        chk("dec_hold", dec_o, hold_zero ? 0 : last_dec);
      end
      prev_valid = dec_valid;
      last_dec = dec_o;
    end
  end

  initial begin
    reset = 1'b1; in_en = 1'b0; bit_in = 1'b0;
    for (int i = 0; i < 400; i++) pat[i] = ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0;
    step(1'b1, 1'b0, 1'b0);
    mon_on = 1'b1;

    // constant ones, gap-free; first strobe is C(49,3) = 18424
    hand_from = 5; hand_val = 125000;
    do_reset();
    run(0, 400, 1'b0);
    drain();
    chk("ones_strobes", cap.size(), 8);
    if (cap.size() > 0) chk("ones_first", cap[0], 18424);
    if (cap.size() > 1) chk("ones_second", cap[1], 101577);
    cap_a = cap;

    // constant zeros
    hand_val = -125000;
    do_reset();
    run(1, 400, 1'b0);
    drain();

    // alternating 1,0 -> mean 0
    hand_val = 0;
    do_reset();
    run(2, 400, 1'b0);
    drain();

    // 1,1,1,1,0 -> mean 0.6
    hand_val = 75000;
    do_reset();
    run(3, 400, 1'b0);
    drain();

    // constant ones with random in_en gaps -> same sequence as gap-free
    hand_val = 125000;
    do_reset();
    run(0, 400, 1'b1);
    drain();
    cap_b = cap;
    cmp_caps("gap_vs_gapfree");

    // mid-stream reset at accepted bit 123 -> matches a fresh run
    hand_from = 0;
    do_reset();
    run(4, 400, 1'b0);
    drain();
    cap_a = cap;
    do_reset();
    run(4, 123, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("midreset_dec_o", dec_o, 0);
    chk("midreset_dec_valid", dec_valid, 0);
    cap.delete();
    run(4, 400, 1'b0);
    drain();
    cap_b = cap;
    cmp_caps("midreset_vs_fresh");

    // long random run against the golden model
    do_reset();
    run(5, 10000, 1'b1);
    drain();
    chk("random_strobes", cap.size(), 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
